if_id_stage_reg: RTL and testbench

//  IF/ID pipeline register of the 5-stage MIPS core. It consumes the hazard

---
 rtl/if_id_stage_reg.sv | 126 ++++++++++++
 tb/tb_if_id_stage_reg.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/if_id_stage_reg.sv
// IF/ID pipeline register for the 5-stage MIPS core.
// Holds, squashes or advances the fetched PC+4 and instruction into ID,
// tracks whether the ID-stage instruction is real, and raises a sticky
// flag when the hazard unit keeps the stage frozen for too long.
// Optional feature macro: IF_ID_PERF_CNT_EN adds the stall_cnt/flush_cnt
// performance counters and their ports.
module if_id_stage_reg #(
    parameter int WORD_WIDTH = 32,
    parameter int MAX_STALL  = 4,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  freeze,
    input  logic                  flush,
    input  logic [WORD_WIDTH-1:0] PC_in,
    input  logic [WORD_WIDTH-1:0] instruction_in,
    output logic [WORD_WIDTH-1:0] PC_out,
    output logic [WORD_WIDTH-1:0] instruction_out,
    output logic                  valid_out,
    output logic                  stall_timeout
`ifdef IF_ID_PERF_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]  stall_cnt,
    output logic [CNT_WIDTH-1:0]  flush_cnt
`endif
);

    // The run counter only needs to reach MAX_STALL; keep at least one bit
    // so a degenerate MAX_STALL of 0 still elaborates.
    localparam int RUN_WIDTH = (MAX_STALL < 1) ? 1 : $clog2(MAX_STALL + 1);
    localparam logic [RUN_WIDTH-1:0] RUN_MAX = RUN_WIDTH'(MAX_STALL);

    logic [WORD_WIDTH-1:0] pc_d, pc_q;
    logic [WORD_WIDTH-1:0] instr_d, instr_q;
    logic                  valid_d, valid_q;
    logic [RUN_WIDTH-1:0]  run_d, run_q;
    logic                  timeout_d, timeout_q;
    logic                  frozen;

    // A cycle only counts as frozen when no flush overrides the freeze.
    assign frozen = freeze & ~flush;

    // Next-state selection: flush squashes, freeze holds, otherwise load.
    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        if (flush) begin
            pc_d    = '0;
            instr_d = '0;
            valid_d = 1'b0;
        end else if (!freeze) begin
            pc_d    = PC_in;
            instr_d = instruction_in;
            valid_d = 1'b1;
        end
    end

    // Consecutive-stall tracking; the timeout latches on the cycle after the
    // counter has already saturated and never clears short of reset.
    always_comb begin
        run_d     = '0;
        timeout_d = timeout_q;
        if (frozen) begin
            run_d = (run_q == RUN_MAX) ? run_q : run_q + RUN_WIDTH'(1);
            if (run_q == RUN_MAX) begin
                timeout_d = 1'b1;
            end
        end
    end

    // Pipeline state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q      <= '0;
            instr_q   <= '0;
            valid_q   <= 1'b0;
            run_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            valid_q   <= valid_d;
            run_q     <= run_d;
            timeout_q <= timeout_d;
        end
    end

    assign PC_out          = pc_q;
    assign instruction_out = instr_q;
    assign valid_out       = valid_q;
    assign stall_timeout   = timeout_q;

`ifdef IF_ID_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] stall_cnt_d, stall_cnt_q;
    logic [CNT_WIDTH-1:0] flush_cnt_d, flush_cnt_q;

    // Free-running event counters that wrap naturally at their width.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (frozen) begin
            stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
        end
        if (flush) begin
            flush_cnt_d = flush_cnt_q + CNT_WIDTH'(1);
        end
    end

    // Performance counter registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_id_stage_reg.sv
// Self-checking bench for if_id_stage_reg: directed vectors with literal
// expectations plus a cycle-by-cycle comparison against a behavioural model.
module tb_if_id_stage_reg;

    localparam int WW        = 32;
    localparam int MAX_STALL = 4;
    localparam int CNT_W     = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          freeze;
    logic          flush;
    logic [WW-1:0] pc_in;
    logic [WW-1:0] instr_in;
    logic [WW-1:0] pc_out;
    logic [WW-1:0] instr_out;
    logic          valid_out;
    logic          stall_timeout;
`ifdef IF_ID_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
`endif

    int checks = 0;
    int errors = 0;

    if_id_stage_reg #(
        .WORD_WIDTH (WW),
        .MAX_STALL  (MAX_STALL),
        .CNT_WIDTH  (CNT_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .freeze          (freeze),
        .flush           (flush),
        .PC_in           (pc_in),
        .instruction_in  (instr_in),
        .PC_out          (pc_out),
        .instruction_out (instr_out),
        .valid_out       (valid_out),
        .stall_timeout   (stall_timeout)
`ifdef IF_ID_PERF_CNT_EN
        ,
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural model: outputs follow the priority rules directly, with an
    // unbounded consecutive-freeze length instead of a saturating counter.
    logic [WW-1:0] m_pc;
    logic [WW-1:0] m_instr;
    logic          m_valid;
    logic          m_timeout;
    int            m_run_len;
    int            m_stalls;
    int            m_flushes;
    logic          m_live = 1'b0;

    always @(posedge clk) begin
        if (!rst) begin
            m_pc      <= '0;
            m_instr   <= '0;
            m_valid   <= 1'b0;
            m_timeout <= 1'b0;
            m_run_len <= 0;
            m_stalls  <= 0;
            m_flushes <= 0;
            m_live    <= 1'b1;
        end else if (flush) begin
            m_pc      <= '0;
            m_instr   <= '0;
            m_valid   <= 1'b0;
            m_run_len <= 0;
            m_flushes <= (m_flushes + 1) % (1 << CNT_W);
        end else if (freeze) begin
            if (m_run_len + 1 > MAX_STALL) m_timeout <= 1'b1;
            m_run_len <= m_run_len + 1;
            m_stalls  <= (m_stalls + 1) % (1 << CNT_W);
        end else begin
            m_pc      <= pc_in;
            m_instr   <= instr_in;
            m_valid   <= 1'b1;
            m_run_len <= 0;
        end
    end

    task automatic checkOutput(input string name, input logic [WW-1:0] actual,
                               input logic [WW-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Compare process: every cycle after the first reset, sampled on negedge.
    always @(negedge clk) begin
        if (m_live) begin
            checkOutput("model_pc", pc_out, m_pc);
            checkOutput("model_instr", instr_out, m_instr);
            checkOutput("model_valid", WW'(valid_out), WW'(m_valid));
            checkOutput("model_timeout", WW'(stall_timeout), WW'(m_timeout));
`ifdef IF_ID_PERF_CNT_EN
            checkOutput("model_stall_cnt", WW'(stall_cnt), WW'(m_stalls));
            checkOutput("model_flush_cnt", WW'(flush_cnt), WW'(m_flushes));
`endif
        end
    end

    // Drive one cycle of inputs and return after the following negedge.
    task automatic applyStimulus(input logic r, input logic fz, input logic fl,
                                 input logic [WW-1:0] pc, input logic [WW-1:0] ins);
        rst      = r;
        freeze   = fz;
        flush    = fl;
        pc_in    = pc;
        instr_in = ins;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0; freeze = 1'b0; flush = 1'b0; pc_in = '0; instr_in = '0;

        // Reset for two cycles with junk on the inputs.
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0000_0040, 32'hDEAD_BEEF);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0000_0044, 32'hDEAD_BEEF);
        checkOutput("reset_pc", pc_out, 32'h0);
        checkOutput("reset_instr", instr_out, 32'h0);
        checkOutput("reset_valid", WW'(valid_out), 32'h0);
        checkOutput("reset_timeout", WW'(stall_timeout), 32'h0);

        // First load.
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h4, 32'h2001_000A);
        checkOutput("load1_pc", pc_out, 32'h4);
        checkOutput("load1_instr", instr_out, 32'h2001_000A);
        checkOutput("load1_valid", WW'(valid_out), 32'h1);

        // Load then hold under freeze, then release.
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h8, 32'h8C22_0004);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 32'hC, 32'hAC23_0008);
            checkOutput("freeze_pc", pc_out, 32'h8);
            checkOutput("freeze_instr", instr_out, 32'h8C22_0004);
            checkOutput("freeze_valid", WW'(valid_out), 32'h1);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 32'hC, 32'hAC23_0008);
        checkOutput("release_pc", pc_out, 32'hC);

        // Flush beats freeze.
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h10, 32'h1111_1111);
        checkOutput("flush_pc", pc_out, 32'h0);
        checkOutput("flush_instr", instr_out, 32'h0);
        checkOutput("flush_valid", WW'(valid_out), 32'h0);
`ifdef IF_ID_PERF_CNT_EN
        checkOutput("flush_stall_cnt", WW'(stall_cnt), 32'd2);
        checkOutput("flush_flush_cnt", WW'(flush_cnt), 32'd1);
`endif

        // Stall timeout on the fifth consecutive frozen cycle.
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h10, 32'h2002_0005);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 32'h14, 32'h0);
            checkOutput("timeout_run", WW'(stall_timeout), (i == 4) ? 32'h1 : 32'h0);
        end
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 32'h18 + WW'(4 * i), 32'h0042_0020 + WW'(i));
            checkOutput("timeout_sticky", WW'(stall_timeout), 32'h1);
        end
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h20, 32'h3333_3333);
        checkOutput("flush_only_valid", WW'(valid_out), 32'h0);
        checkOutput("flush_keeps_timeout", WW'(stall_timeout), 32'h1);

        // Reset in the middle of a stall, with flush also asserted.
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, 32'h24, 32'h5);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h28, 32'h6);
        checkOutput("midreset_pc", pc_out, 32'h0);
        checkOutput("midreset_valid", WW'(valid_out), 32'h0);
        checkOutput("midreset_timeout", WW'(stall_timeout), 32'h0);
`ifdef IF_ID_PERF_CNT_EN
        checkOutput("midreset_stall_cnt", WW'(stall_cnt), 32'h0);
        checkOutput("midreset_flush_cnt", WW'(flush_cnt), 32'h0);
`endif

        // Seventeen frozen cycles straight out of reset.
        for (int i = 0; i < 17; i++) applyStimulus(1'b1, 1'b1, 1'b0, 32'h2C, 32'h7);
        checkOutput("long_freeze_valid", WW'(valid_out), 32'h0);
        checkOutput("long_freeze_timeout", WW'(stall_timeout), 32'h1);
`ifdef IF_ID_PERF_CNT_EN
        checkOutput("stall_cnt_wrap", WW'(stall_cnt), 32'h1);
`endif

        // A short mixed tail for the model comparison.
        for (int i = 0; i < 8; i++)
            applyStimulus(1'b1, (i % 3) == 1, (i % 4) == 3, 32'h100 + WW'(4 * i),
                          32'hA000_0000 + WW'(i));
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h200, 32'hCAFE_F00D);
        checkOutput("tail_pc", pc_out, 32'h200);
        checkOutput("tail_instr", instr_out, 32'hCAFE_F00D);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
